// File: rtl/muxn_pipe_if.sv
// Handshake/data bundle for muxn_pipe: upstream beat (data, select, valid/ready)
// and downstream registered result (data, error sideband, valid/ready).
interface muxn_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_IN)
);
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [SEL_WIDTH-1:0]         in_sel;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_err;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/muxn_pipe.sv
// NUM_IN-way registered selector with a 2-entry skid buffer and valid/ready handshake.
// Optional synchronous flush port enabled by defining MUXN_PIPE_FLUSH_EN.
module muxn_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MUXN_PIPE_FLUSH_EN
    input  logic        flush,
`endif
    muxn_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_err_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  skid_err_r;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  sel_err_s;
    logic                  load_out_in_s;
    logic                  load_out_skid_s;
    logic                  load_skid_s;
    logic                  flush_s;

`ifdef MUXN_PIPE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Channel select; out-of-range codes (incl. unused codes when NUM_IN is not a power of two) flag an error.
    always_comb begin
        sel_data_s = {DATA_WIDTH{1'b0}};
        sel_err_s  = 1'b1;
        if (32'(bus.in_sel) < NUM_IN) begin
            sel_data_s = bus.in_data[32'(bus.in_sel)*DATA_WIDTH +: DATA_WIDTH];
            sel_err_s  = 1'b0;
        end else begin
            sel_data_s = {DATA_WIDTH{1'b0}};
            sel_err_s  = 1'b1;
        end
    end

    // Next-state and load-enable decode; in_valid is ignored while FULL.
    always_comb begin
        state_nxt_s     = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (flush_s) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (bus.in_valid) begin
                        load_out_in_s = 1'b1;
                        state_nxt_s   = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (bus.in_valid && bus.out_ready) begin
                        load_out_in_s = 1'b1;
                        state_nxt_s   = ONE;
                    end else if (bus.in_valid) begin
                        load_skid_s = 1'b1;
                        state_nxt_s = FULL;
                    end else if (bus.out_ready) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        load_out_skid_s = 1'b1;
                        state_nxt_s     = ONE;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, output register and skid register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_err_r   <= 1'b0;
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            if (load_out_in_s) begin
                out_data_r <= sel_data_s;
                out_err_r  <= sel_err_s;
            end else if (load_out_skid_s) begin
                out_data_r <= skid_data_r;
                out_err_r  <= skid_err_r;
            end else begin
                out_data_r <= out_data_r;
                out_err_r  <= out_err_r;
            end
            if (load_skid_s) begin
                skid_data_r <= sel_data_s;
                skid_err_r  <= sel_err_s;
            end else begin
                skid_data_r <= skid_data_r;
                skid_err_r  <= skid_err_r;
            end
        end
    end

    // Ready depends only on registered state; held low while reset is asserted.
    assign bus.in_ready  = ~rst & (state_r != FULL);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench: a 4-input and a 3-input muxn_pipe share one handshake stream
// and are compared against a queue-based model of a 2-deep buffered selector.
module tb_muxn_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] chan [4];
    logic        accepted = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] q4[$];
    logic [32:0] q3[$];

    muxn_pipe_if #(.DATA_WIDTH(32), .NUM_IN(4)) b4();
    muxn_pipe_if #(.DATA_WIDTH(32), .NUM_IN(3)) b3();

    assign b4.in_data   = {chan[3], chan[2], chan[1], chan[0]};
    assign b3.in_data   = {chan[2], chan[1], chan[0]};
    assign b4.in_sel    = sel;
    assign b3.in_sel    = sel;
    assign b4.in_valid  = in_valid;
    assign b3.in_valid  = in_valid;
    assign b4.out_ready = out_ready;
    assign b3.out_ready = out_ready;

    muxn_pipe #(.DATA_WIDTH(32), .NUM_IN(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
`ifdef MUXN_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .bus  (b4.slave)
    );

    muxn_pipe #(.DATA_WIDTH(32), .NUM_IN(3)) dut3 (
        .clk  (clk),
        .rst  (rst),
`ifdef MUXN_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .bus  (b3.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected beat {err, data} for a selector with n channels.
    function automatic logic [32:0] ref_beat(input int n, input int s);
        if (s < n) return {1'b0, chan[s]};
        return {1'b1, 32'h0000_0000};
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        int          cnt;
        logic        acc;
        logic        pop;
        logic [32:0] e4;
        logic [32:0] e3;
        @(negedge clk);
        cnt = q4.size();
        if (rst) begin
            check("in_ready_rst4", 64'(b4.in_ready), 64'd0);
            check("in_ready_rst3", 64'(b3.in_ready), 64'd0);
        end else begin
            check("in_ready4", 64'(b4.in_ready), 64'(cnt < 2));
            check("in_ready3", 64'(b3.in_ready), 64'(cnt < 2));
            check("out_valid4", 64'(b4.out_valid), 64'(cnt > 0));
            check("out_valid3", 64'(b3.out_valid), 64'(cnt > 0));
            if (cnt > 0) begin
                check("out_data4", 64'(b4.out_data), 64'(q4[0][31:0]));
                check("out_err4",  64'(b4.out_err),  64'(q4[0][32]));
                check("out_data3", 64'(b3.out_data), 64'(q3[0][31:0]));
                check("out_err3",  64'(b3.out_err),  64'(q3[0][32]));
            end
        end
        acc = !rst && !flush && in_valid && (cnt < 2);
        pop = !rst && !flush && out_ready && (cnt > 0);
        e4  = ref_beat(4, int'(sel));
        e3  = ref_beat(3, int'(sel));
        @(posedge clk);
        if (rst || flush) begin
            q4.delete();
            q3.delete();
        end else begin
            if (pop) begin
                void'(q4.pop_front());
                void'(q3.pop_front());
            end
            if (acc) begin
                q4.push_back(e4);
                q3.push_back(e3);
            end
        end
        accepted = acc;
        #1;
        if (rst) begin
            check("rst_out_valid4", 64'(b4.out_valid), 64'd0);
            check("rst_out_data4",  64'(b4.out_data),  64'd0);
            check("rst_out_err4",   64'(b4.out_err),   64'd0);
            check("rst_out_valid3", 64'(b3.out_valid), 64'd0);
            check("rst_out_data3",  64'(b3.out_data),  64'd0);
            check("rst_out_err3",   64'(b3.out_err),   64'd0);
        end
    endtask

    task automatic offer(input logic v, input logic [1:0] s);
        in_valid = v;
        sel      = s;
    endtask

    initial begin
        chan[0] = 32'hAAAA_0000;
        chan[1] = 32'hAAAA_0001;
        chan[2] = 32'hAAAA_0002;
        chan[3] = 32'hAAAA_0003;

        // Reset held for two cycles, then idle.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Streaming with sel 0..3 (sel 3 is illegal on the 3-input instance), then sel 0.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 2'(i));
            step();
        end
        offer(1'b1, 2'd0);
        step();
        offer(1'b0, 2'd0);
        step();
        step();

        // Backpressure: fill both entries, hold a third beat, then drain in order.
        out_ready = 1'b0;
        offer(1'b1, 2'd1);
        step();
        offer(1'b1, 2'd2);
        step();
        offer(1'b1, 2'd3);
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        offer(1'b0, 2'd0);
        step();
        step();
        step();

        // Reset while FULL with a beat offered: nothing buffered may reappear.
        out_ready = 1'b0;
        offer(1'b1, 2'd1);
        step();
        offer(1'b1, 2'd2);
        step();
        rst = 1'b1;
        offer(1'b1, 2'd3);
        step();
        rst = 1'b0;
        offer(1'b0, 2'd0);
        out_ready = 1'b1;
        step();
        step();
        step();

`ifdef MUXN_PIPE_FLUSH_EN
        // Flush while FULL with a coincident beat: both entries and the beat vanish.
        out_ready = 1'b0;
        offer(1'b1, 2'd0);
        step();
        offer(1'b1, 2'd1);
        step();
        flush = 1'b1;
        offer(1'b1, 2'd2);
        step();
        flush = 1'b0;
        offer(1'b0, 2'd0);
        out_ready = 1'b1;
        step();
        step();
        step();
`endif

        // Randomized traffic; an offered beat is held until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !accepted)) begin
                for (int k = 0; k < 4; k++) chan[k] = $urandom;
                offer($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        offer(1'b0, 2'd0);
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised successor to the pipeline's fixed 3-way operand/result selectors.
- Selects one of NUM_IN data channels with a binary select and registers the result.
- Provides a valid/ready handshake with a 2-entry skid buffer, so the datapath can stall without a combinational ready path.
- Sits between execute-stage result sources and the next pipeline register (writeback/forwarding select).

Parameters:
- DATA_WIDTH, 32, width of each data channel.
- NUM_IN, 4, number of selectable channels; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_IN), select width; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*DATA_WIDTH  packed channels; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_sel  input  SEL_WIDTH  binary channel select, sampled with in_valid.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  DATA_WIDTH  registered selected data.
- out_err  output  1  sideband: in_sel was >= NUM_IN for this beat.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst, and rst is sampled only on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_err=0, skid register cleared, state=EMPTY.
- in_ready is 0 while rst=1, and 1 on the first cycle after reset.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - Upstream must hold in_data/in_sel stable while in_valid && !in_ready.
  - Once out_valid=1, out_data/out_err stay stable until transfer out.
- Selection:
  - sel_data = channel in_sel when in_sel < NUM_IN.
  - Otherwise sel_data = 0 and sel_err = 1. The error travels with its beat; there is no sticky error.
- Latency: 1 cycle. A beat accepted at edge N is presented on out_* after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready = (state != FULL). It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- State EMPTY (out_valid=0):
  - in_valid → out_reg<=sel, go to ONE.
  - Otherwise stay in EMPTY.
- State ONE (out_valid=1, skid empty):
  - in_valid && out_ready → out_reg<=new beat, stay in ONE.
  - in_valid && !out_ready → skid<=new beat, go to FULL.
  - !in_valid && out_ready → go to EMPTY.
  - Otherwise hold.
- State FULL (out_valid=1, skid valid, in_ready=0):
  - out_ready → out_reg<=skid, go to ONE.
  - Otherwise hold.
  - in_valid is ignored in FULL.
- Ordering: beats exit in acceptance order. No beat is dropped or duplicated.
- Reset mid-operation: rst wins over all events in the same cycle. Both buffered beats are discarded, with no partial output.
- NUM_IN not a power of two: unused select codes give the error path above.

Optional Feature:
- Macro: MUXN_PIPE_FLUSH_EN.
- Defined:
  - Adds port "flush input 1", a synchronous pipeline flush (e.g. branch mispredict).
  - flush=1 at an edge sets state=EMPTY and out_valid=0, and discards both entries.
  - A same-cycle in_valid beat is not accepted, even though in_ready may read 1.
  - rst has priority over flush.
  - out_data/out_err are not cleared by flush; they are don't-care while out_valid=0.
- Undefined: the port is absent and the behaviour is identical to flush tied to 0.

Test Plan:
- Reset then idle: rst high 2 cycles → out_valid=0, out_data=0, out_err=0, in_ready=0 during reset and 1 after.
- Stream, NUM_IN=4, DATA_WIDTH=32: in_data channels {0xAAAA0003, 0xAAAA0002, 0xAAAA0001, 0xAAAA0000} (k=3..0), sel 0,1,2,3 on consecutive cycles, out_ready=1 → out_data 0xAAAA0000..0xAAAA0003 on cycles 1..4, in_ready stays 1, out_err=0.
- Backpressure: out_ready=0, push beats sel=1 then sel=2 → after 2 edges state FULL and in_ready=0. Third beat (sel=3) is held. Raise out_ready → outputs 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 in order with no loss.
- Illegal select, NUM_IN=3: in_sel=3 → out_data=0, out_err=1 for that beat only. The next beat with sel=0 gives out_err=0.
- Reset mid-stream: state FULL and rst=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and no stale beat is emitted afterwards.
- With MUXN_PIPE_FLUSH_EN: state FULL, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed and coincident beats never appear on the output.
